main_control_fsm: RTL and testbench
===================================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL have parameter CNTW, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port Opcode, input, 6, instruction opcode from the instruction register.
REQ-005 SHALL have port MemReady, input, 1, memory access complete this cycle.
REQ-006 SHALL have control output ports, each 1 bit: IorD, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA.
REQ-007 SHALL have control output ports, each 2 bits: ALUSrcB, ALUOp, PCSource.
REQ-008 SHALL have port IllegalOp, output, 1, one-cycle pulse on an unsupported opcode.
REQ-009 SHALL have port State, output, 4, current state encoding for debug.
REQ-010 SHALL have port Retired, output, CNTW, count of completed instructions.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH.
REQ-012 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1; the state SHALL be held until MemReady=1, with IRWrite and PCWrite asserted only in the MemReady=1 cycle.
REQ-013 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by Opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other -> FETCH with IllegalOp=1 for exactly that DECODE cycle.
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD if Opcode=100011, else MEMWR.
REQ-015 MEMRD: MemRead=1, IorD=1; hold until MemReady=1, then go to MEMWB.
REQ-016 MEMWR: MemWrite=1, IorD=1; hold until MemReady=1, then go to FETCH.
REQ-017 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next state FETCH.
REQ-018 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-019 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next state FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next state FETCH.
REQ-021 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state ADDIWB.
REQ-022 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next state FETCH.
REQ-023 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-024 Every control output not listed for a state SHALL be 0 in that state, and all outputs SHALL be decoded from the registered state only (MemReady gating per REQ-012 excepted).
REQ-025 Retired SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP, SHALL wrap modulo 2^CNTW, and SHALL NOT increment on the illegal-opcode exit.
REQ-026 MemReady SHALL be ignored in all states other than FETCH, MEMRD and MEMWR.

Reset
REQ-027 Asserting rst SHALL, asynchronously and at any point including mid-instruction or during a memory wait, force State=FETCH, Retired=0 and IllegalOp=0.
REQ-028 After rst is released, the first FETCH memory request SHALL be issued on the first rising clk edge.

Structure
REQ-029 The state enum, the opcode constants (RTYPE, LW, SW, BEQ, ADDI, J) and the ALUOp/ALUSrcB/PCSource encodings SHALL live in the shared package mips_ctrl_pkg.
REQ-030 The output decode SHALL be a combinational sub-module ctrl_decode (state and MemReady in, control word out); next-state logic, state register and counter SHALL stay in main_control_fsm.

Verification
REQ-031 R-type: Opcode=000000, MemReady=1 -> states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in ALUWB; Retired 0 -> 1.
REQ-032 lw with a fetch wait: MemReady=0 for 3 cycles in FETCH -> State stays 0 with IRWrite=0; then path 0,1,2,3,4,0 with MemtoReg=1 in MEMWB; Retired=1.
REQ-033 sw, then beq, then j -> paths 0,1,2,5,0 / 0,1,8,0 / 0,1,11,0; PCWriteCond=1 only in BRANCH, PCSource=10 in JUMP; Retired=3.
REQ-034 Illegal Opcode=111111 -> path 0,1,0; IllegalOp pulses for 1 cycle; Retired unchanged.
REQ-035 Reset mid-instruction: assert rst asynchronously in MEMRD while MemReady=0 -> State=0 and Retired=0 immediately, before the next clk edge.
REQ-036 Wrap: with CNTW=4, run 16 addi instructions -> Retired returns to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: state codes, opcodes,
// datapath mux/ALU selects and the decoded control word.
package mips_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t StFetch  = 4'd0;
    localparam state_t StDecode = 4'd1;
    localparam state_t StMemAdr = 4'd2;
    localparam state_t StMemRd  = 4'd3;
    localparam state_t StMemWb  = 4'd4;
    localparam state_t StMemWr  = 4'd5;
    localparam state_t StExec   = 4'd6;
    localparam state_t StAluWb  = 4'd7;
    localparam state_t StBranch = 4'd8;
    localparam state_t StAddiEx = 4'd9;
    localparam state_t StAddiWb = 4'd10;
    localparam state_t StJump   = 4'd11;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] J     = 6'b000010;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBBrOff = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == RTYPE) || (op == LW) || (op == SW) || (op == BEQ) ||
               (op == ADDI) || (op == J);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode of the main control FSM; only FETCH looks at mem_ready, to
// gate IR/PC writes to the cycle the instruction word actually arrives.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SrcBFour;
                ctrl.alu_op    = AluOpAdd;
                ctrl.pc_source = PcSrcAlu;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            StDecode: begin
                ctrl.alu_src_b = SrcBBrOff;
                ctrl.alu_op    = AluOpAdd;
            end
            StMemAdr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluOpAdd;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            StMemWb: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            StExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBReg;
                ctrl.alu_op    = AluOpFunct;
            end
            StAluWb: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SrcBReg;
                ctrl.alu_op        = AluOpSub;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PcSrcAluOut;
            end
            StAddiEx: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluOpAdd;
            end
            StAddiWb: begin
                ctrl.reg_write = 1'b1;
            end
            StJump: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PcSrcJump;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control: state register, next-state logic and retired-instruction
// counter; control word decoding lives in ctrl_decode.
module main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      Opcode,
    input  logic            MemReady,
    output logic            IorD,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IRWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic            IllegalOp,
    output logic [3:0]      State,
    output logic [CNTW-1:0] Retired
);

    state_t          state_q, state_d;
    logic [CNTW-1:0] retired_q;
    logic            retire;
    ctrl_t           ctrl;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (MemReady) state_d = StDecode;
            StDecode: begin
                case (Opcode)
                    LW, SW:  state_d = StMemAdr;
                    RTYPE:   state_d = StExec;
                    BEQ:     state_d = StBranch;
                    ADDI:    state_d = StAddiEx;
                    J:       state_d = StJump;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = (Opcode == LW) ? StMemRd : StMemWr;
            StMemRd:  if (MemReady) state_d = StMemWb;
            StMemWr:  if (MemReady) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StAluWb, StBranch, StAddiWb, StJump: state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    // Only a completed instruction counts; the illegal-opcode exit from DECODE does not.
    always_comb begin
        retire = 1'b0;
        if (state_d == StFetch) begin
            case (state_q)
                StMemWb, StMemWr, StAluWb, StBranch, StAddiWb, StJump: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    ctrl_decode u_ctrl_decode (
        .state     (state_q),
        .mem_ready (MemReady),
        .ctrl      (ctrl)
    );

    assign IorD        = ctrl.iord;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IRWrite     = ctrl.ir_write;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;

    assign IllegalOp = (state_q == StDecode) && !is_legal_op(Opcode);
    assign State     = state_q;
    assign Retired   = retired_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench: stimulus pushes expected per-cycle outputs, a negedge monitor compares.
module tb_main_control_fsm;

    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [5:0]      Opcode = 6'd0;
    logic            MemReady = 1'b0;
    logic            IorD, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite;
    logic            MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0]      ALUSrcB, ALUOp, PCSource;
    logic [3:0]      State;
    logic [CNTW-1:0] Retired;

    main_control_fsm #(.CNTW(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .Opcode      (Opcode),
        .MemReady    (MemReady),
        .IorD        (IorD),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IRWrite     (IRWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .IllegalOp   (IllegalOp),
        .State       (State),
        .Retired     (Retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      st;
        logic [15:0]     ctl;
        logic            ill;
        logic [CNTW-1:0] ret;
    } exp_t;

    exp_t            exp_q[$];
    int              total = 0;
    int              bad = 0;
    logic [CNTW-1:0] model_ret = '0;

    logic [15:0] act_ctl;
    assign act_ctl = {IorD, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, MemtoReg,
                      RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, want);
        end
    endtask

    // Control table written straight from the state descriptions.
    function automatic logic [15:0] exp_ctl(input int s, input logic mr);
        logic iord, pcw, pcwc, irw, mrd, mwr, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        {iord, pcw, pcwc, irw, mrd, mwr, m2r, rdst, rw, srca} = '0;
        srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
        case (s)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aluop = 2'b10; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
            9:  begin srca = 1; srcb = 2'b10; end
            10: rw = 1;
            11: begin pcw = 1; pcsrc = 2'b10; end
            default: ;
        endcase
        return {iord, pcw, pcwc, irw, mrd, mwr, m2r, rdst, rw, srca, srcb, aluop, pcsrc};
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    endfunction

    task automatic step(input int s, input logic mr, input logic ill, input logic [5:0] op);
        exp_t e;
        @(posedge clk);
        #1;
        MemReady = mr;
        Opcode   = op;
        e.st  = s[3:0];
        e.ctl = exp_ctl(s, mr);
        e.ill = ill;
        e.ret = model_ret;
        exp_q.push_back(e);
    endtask

    // One instruction; optionally abort with an asynchronous reset while waiting in MEMRD.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
        int path[$];
        bit ok;
        ok = legal(op);
        case (op)
            6'h23:   path = '{0, 1, 2, 3, 4};
            6'h2B:   path = '{0, 1, 2, 5};
            6'h00:   path = '{0, 1, 6, 7};
            6'h04:   path = '{0, 1, 8};
            6'h08:   path = '{0, 1, 9, 10};
            6'h02:   path = '{0, 1, 11};
            default: path = '{0, 1};
        endcase
        foreach (path[i]) begin
            int s;
            s = path[i];
            if (s == 0 || s == 3 || s == 5) begin
                repeat ((s == 0) ? fw : mw) step(s, 1'b0, 1'b0, op);
                if (abort && s == 3) begin
                    @(negedge clk);
                    #2;
                    rst = 1'b1;
                    #1;
                    chk("async_rst_state", 32'(State), 32'd0);
                    chk("async_rst_retired", 32'(Retired), 32'd0);
                    chk("async_rst_illegal", 32'(IllegalOp), 32'd0);
                    chk("async_rst_memread", 32'(MemRead), 32'd1);
                    model_ret = '0;
                    #1;
                    rst = 1'b0;
                    return;
                end
                step(s, 1'b1, 1'b0, op);
            end else begin
                step(s, 1'($urandom_range(0, 1)), (s == 1) && !ok, op);
            end
        end
        if (ok) model_ret = model_ret + 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state", 32'(State), 32'(e.st));
            chk("ctrl", 32'(act_ctl), 32'(e.ctl));
            chk("illegal_op", 32'(IllegalOp), 32'(e.ill));
            chk("retired", 32'(Retired), 32'(e.ret));
        end
    end

    initial begin
        logic [5:0] ops [6];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
        @(negedge clk);
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_retired", 32'(Retired), 32'd0);
        chk("reset_illegal", 32'(IllegalOp), 32'd0);
        chk("reset_irwrite", 32'(IRWrite), 32'd0);
        #1;
        rst = 1'b0;

        run_instr(6'h00, 0, 0, 1'b0);
        run_instr(6'h23, 3, 1, 1'b0);
        run_instr(6'h2B, 0, 2, 1'b0);
        run_instr(6'h04, 1, 0, 1'b0);
        run_instr(6'h02, 0, 0, 1'b0);
        run_instr(6'h3F, 0, 0, 1'b0);
        run_instr(6'h23, 0, 2, 1'b1);

        repeat (16) run_instr(6'h08, 0, 0, 1'b0);
        step(0, 1'b0, 1'b0, 6'h08);
        @(negedge clk);
        #1;
        chk("retired_wrap", 32'(Retired), 32'd0);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
